hamming_tx_sched: RTL and testbench

Two-requester scheduler sequencing the registered Hamming(12,8) encoder in the transceiver TX path. It accepts bytes from two sources (payload, control) over valid/ready and arbitrates between them. It drives the encoder's write strobe and data, then captures the 12-bit codeword in the single cycle the encoder presents it. The codeword goes downstream to the serializer over valid/ready, tagged with its source.

---
 rtl/hamming_pkg.sv | 14 +
 rtl/hamming_tx_sched_if.sv | 36 +++
 rtl/hamming_rr_arb2.sv | 23 ++
 rtl/hamming_tx_sched.sv | 108 ++++++++++
 tb/tb_hamming_tx_sched.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths and scheduler state encoding for the Hamming(12,8) TX path
package hamming_pkg;

    localparam int CW_W   = 12;
    localparam int DATA_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ENC  = 2'd1;
    localparam state_t CAPT = 2'd2;
    localparam state_t OUT  = 2'd3;

endpackage

// File: rtl/hamming_tx_sched_if.sv
// rtl/hamming_tx_sched_if.sv - requester, encoder and codeword signals of hamming_tx_sched
interface hamming_tx_sched_if #(
    parameter int CNT_W = 16
);
    import hamming_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [DATA_W-1:0] req0_data;
    logic [DATA_W-1:0] req1_data;
    logic              req0_ready;
    logic              req1_ready;
    logic              enc_wren;
    logic [DATA_W-1:0] enc_data;
    logic [CW_W-1:0]   enc_hc;
    logic              cw_valid;
    logic [CW_W-1:0]   cw_data;
    logic              cw_src;
    logic              cw_ready;
    logic              busy;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, enc_hc, cw_ready,
        input  req0_ready, req1_ready, enc_wren, enc_data, cw_valid, cw_data, cw_src,
               busy, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, enc_hc, cw_ready,
        output req0_ready, req1_ready, enc_wren, enc_data, cw_valid, cw_data, cw_src,
               busy, cnt0, cnt1
    );

endinterface

// File: rtl/hamming_rr_arb2.sv
// rtl/hamming_rr_arb2.sv - combinational two-way grant, round-robin or fixed priority
module hamming_rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       any_valid,
    output logic       grant
);

    assign any_valid = |req_valid;

    // A tie goes to whoever was not granted last; without RR requester 0 always wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11 && RR_EN) begin
            grant = ~last_grant;
        end
    end

endmodule

// File: rtl/hamming_tx_sched.sv
// rtl/hamming_tx_sched.sv - schedules two byte sources through the registered Hamming(12,8) encoder
module hamming_tx_sched #(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_tx_sched_if.slave  bus
);
    import hamming_pkg::*;

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              src_q;
    logic              grant;
    logic              any_valid;
    logic              accept;
    logic              cw_fire;
    logic              enc_wren_q;
    logic [DATA_W-1:0] enc_data_q;
    logic              cw_valid_q;
    logic [CW_W-1:0]   cw_data_q;
    logic              cw_src_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    hamming_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .req_valid  ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .any_valid  (any_valid),
        .grant      (grant)
    );

    assign accept  = (state_q == IDLE) && any_valid;
    assign cw_fire = (state_q == OUT) && cw_valid_q && bus.cw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = ENC;
            ENC:     state_d = CAPT;
            CAPT:    state_d = OUT;
            OUT:     if (cw_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        bus.busy       = (state_q != IDLE);
    end

    // The encoder only presents its codeword in the cycle after the write strobe, hence CAPT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            src_q        <= 1'b0;
            enc_wren_q   <= 1'b0;
            enc_data_q   <= '0;
            cw_valid_q   <= 1'b0;
            cw_data_q    <= '0;
            cw_src_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            if (accept) begin
                enc_data_q   <= grant ? bus.req1_data : bus.req0_data;
                enc_wren_q   <= 1'b1;
                src_q        <= grant;
                last_grant_q <= grant;
            end else if (state_q == ENC) begin
                enc_wren_q <= 1'b0;
            end
            if (state_q == CAPT) begin
                cw_data_q  <= bus.enc_hc;
                cw_src_q   <= src_q;
                cw_valid_q <= 1'b1;
            end
            if (cw_fire) begin
                cw_valid_q <= 1'b0;
                if (cw_src_q) begin
                    cnt1_q <= cnt1_q + CNT_W'(1);
                end else begin
                    cnt0_q <= cnt0_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.enc_wren = enc_wren_q;
    assign bus.enc_data = enc_data_q;
    assign bus.cw_valid = cw_valid_q;
    assign bus.cw_data  = cw_data_q;
    assign bus.cw_src   = cw_src_q;
    assign bus.cnt0     = cnt0_q;
    assign bus.cnt1     = cnt1_q;

endmodule

// File: tb/tb_hamming_tx_sched.sv
// tb/tb_hamming_tx_sched.sv - bench for hamming_tx_sched: round-robin instance and narrow-counter fixed-priority instance
module tb_hamming_tx_sched;
    import hamming_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hamming_tx_sched_if #(.CNT_W(16)) ia ();
    hamming_tx_sched_if #(.CNT_W(2))  ib ();

    hamming_tx_sched #(.RR_EN(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    hamming_tx_sched #(.RR_EN(1'b0), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        int          grant;
        int          acc_cyc;
        int          lat;
        logic [11:0] cw;
        logic        src;
        logic        wren_t1;
        logic        busy_t1;
        logic        saw_r1;
        logic        both;
        logic        stable;
        logic        cwv_after;
        logic [15:0] c0_after;
        logic [15:0] c1_after;
    } txn_obs_t;

    bit last_m [2];
    int cnt_m [2][2];
    int cnt_mod [2] = '{65536, 4};

    // Data bits go to positions 3,5,6,7,9,10,11,12; parity p covers every position with bit p set.
    function automatic logic [11:0] ham_enc(input logic [7:0] d);
        int dp [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        int pp [4] = '{1, 2, 4, 8};
        logic [11:0] c = '0;
        for (int i = 0; i < 8; i++) c[dp[i]-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            logic par = 1'b0;
            for (int q = 1; q <= 12; q++)
                if ((q & pp[k]) != 0 && q != pp[k]) par ^= c[q-1];
            c[pp[k]-1] = par;
        end
        return c;
    endfunction

    function automatic int arb(input bit rr, input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        return (rr && last == 1'b0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ia.enc_hc <= '0;
        else        ia.enc_hc <= ia.enc_wren ? ham_enc(ia.enc_data) : 12'h000;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ib.enc_hc <= '0;
        else        ib.enc_hc <= ib.enc_wren ? ham_enc(ib.enc_data) : 12'h000;

    task automatic drive(input bit sel, input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        if (sel) begin
            ib.req0_valid = v0; ib.req0_data = d0; ib.req1_valid = v1; ib.req1_data = d1;
        end else begin
            ia.req0_valid = v0; ia.req0_data = d0; ia.req1_valid = v1; ia.req1_data = d1;
        end
    endtask

    task automatic set_cw_ready(input bit sel, input logic v);
        if (sel) ib.cw_ready = v;
        else     ia.cw_ready = v;
    endtask

    task automatic peek(input bit sel, output logic r0, output logic r1, output logic wren,
                        output logic cwv, output logic src, output logic busy,
                        output logic [11:0] cw, output logic [15:0] c0, output logic [15:0] c1);
        if (sel) begin
            r0 = ib.req0_ready; r1 = ib.req1_ready; wren = ib.enc_wren; cwv = ib.cw_valid;
            src = ib.cw_src; busy = ib.busy; cw = ib.cw_data; c0 = 16'(ib.cnt0); c1 = 16'(ib.cnt1);
        end else begin
            r0 = ia.req0_ready; r1 = ia.req1_ready; wren = ia.enc_wren; cwv = ia.cw_valid;
            src = ia.cw_src; busy = ia.busy; cw = ia.cw_data; c0 = ia.cnt0; c1 = ia.cnt1;
        end
    endtask

    // Offers bytes, observes one full transaction; stall > 0 holds cw_ready low that many OUT cycles.
    task automatic do_txn(input bit sel, input bit v0, input logic [7:0] d0, input bit v1,
                          input logic [7:0] d1, input int stall, output txn_obs_t o);
        logic r0, r1, wren, cwv, src, busy;
        logic [11:0] cw;
        logic [15:0] c0, c1, c0s, c1s;
        int n;
        o = '{default: '0};
        o.stable = 1'b1;
        o.lat = -1;
        o.grant = -1;
        drive(sel, v0, d0, v1, d1);
        n = 0;
        forever begin
            #1;
            peek(sel, r0, r1, wren, cwv, src, busy, cw, c0, c1);
            if (r1) o.saw_r1 = 1'b1;
            if (r0 || r1 || n == 20) break;
            n++;
            @(posedge clk);
            #1;
        end
        if (!(r0 || r1)) begin
            drive(sel, 1'b0, 8'h00, 1'b0, 8'h00);
            return;
        end
        o.grant = r1 ? 1 : 0;
        o.both = r0 && r1;
        o.acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (stall == 0) drive(sel, 1'b0, 8'h00, 1'b0, 8'h00);
        peek(sel, r0, r1, wren, cwv, src, busy, cw, c0, c1);
        o.wren_t1 = wren;
        o.busy_t1 = busy;
        n = 1;
        while (!cwv && n < 20) begin
            @(posedge clk);
            #1;
            peek(sel, r0, r1, wren, cwv, src, busy, cw, c0, c1);
            n++;
        end
        if (!cwv) begin
            drive(sel, 1'b0, 8'h00, 1'b0, 8'h00);
            return;
        end
        o.lat = n;
        o.cw = cw;
        o.src = src;
        c0s = c0;
        c1s = c1;
        if (stall > 0) begin
            set_cw_ready(sel, 1'b0);
            for (int i = 0; i < stall; i++) begin
                peek(sel, r0, r1, wren, cwv, src, busy, cw, c0, c1);
                if (cw !== o.cw || src !== o.src || r0 !== 1'b0 || r1 !== 1'b0 || wren !== 1'b0 ||
                    cwv !== 1'b1 || c0 !== c0s || c1 !== c1s) o.stable = 1'b0;
                @(posedge clk);
                #1;
            end
            set_cw_ready(sel, 1'b1);
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00, 1'b0, 8'h00);
        peek(sel, r0, r1, wren, cwv, src, busy, cw, c0, c1);
        o.cwv_after = cwv;
        o.c0_after = c0;
        o.c1_after = c1;
    endtask

    task automatic model_accept(input bit sel, input int g);
        last_m[sel] = (g == 1);
        cnt_m[sel][g] = (cnt_m[sel][g] + 1) % cnt_mod[sel];
    endtask

    task automatic test_reset;
        checks++; if (ia.cw_valid !== 1'b0) begin errors++; $display("FAIL rst_cw_valid got %b exp 0", ia.cw_valid); end
        checks++; if (ia.enc_wren !== 1'b0) begin errors++; $display("FAIL rst_enc_wren got %b exp 0", ia.enc_wren); end
        checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ia.busy); end
        checks++; if (ia.cnt0 !== 16'h0 || ia.cnt1 !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", ia.cnt0, ia.cnt1); end
        checks++; if (ib.cw_data !== 12'h0 || ib.enc_data !== 8'h0) begin errors++; $display("FAIL rst_data got %h/%h exp 0/0", ib.cw_data, ib.enc_data); end
    endtask

    task automatic test_known_vectors;
        txn_obs_t o;
        do_txn(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 0, o);
        model_accept(1'b0, 0);
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL ff_latency got %0d exp 3", o.lat); end
        checks++; if (o.cw !== 12'hF77 || o.src !== 1'b0) begin errors++; $display("FAIL ff_cw got %h src %b exp f77 src 0", o.cw, o.src); end
        checks++; if (o.wren_t1 !== 1'b1 || o.busy_t1 !== 1'b1) begin errors++; $display("FAIL ff_wren_busy got %b%b exp 11", o.wren_t1, o.busy_t1); end
        checks++; if (o.c0_after !== 16'd1 || o.cwv_after !== 1'b0) begin errors++; $display("FAIL ff_cnt0 got %0d cwv %b exp 1 cwv 0", o.c0_after, o.cwv_after); end
        do_txn(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 0, o);
        model_accept(1'b0, 1);
        checks++; if (o.cw !== 12'h007 || o.src !== 1'b1) begin errors++; $display("FAIL x01_cw got %h src %b exp 007 src 1", o.cw, o.src); end
        do_txn(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 0, o);
        model_accept(1'b0, 1);
        checks++; if (o.lat !== 3 || o.cw !== 12'h000 || o.src !== 1'b1) begin errors++; $display("FAIL x00_cw got lat %0d cw %h src %b exp 3 000 1", o.lat, o.cw, o.src); end
        checks++; if (o.c1_after !== 16'd2) begin errors++; $display("FAIL x00_cnt1 got %0d exp 2", o.c1_after); end
    endtask

    task automatic test_round_robin;
        txn_obs_t o;
        int prev = 0;
        int g;
        for (int k = 0; k < 8; k++) begin
            g = arb(1'b1, 1'b1, 1'b1, last_m[0]);
            do_txn(1'b0, 1'b1, 8'hA0, 1'b1, 8'hB1, 0, o);
            model_accept(1'b0, g);
            checks++; if (o.grant !== g || o.both !== 1'b0) begin errors++; $display("FAIL rr_grant[%0d] got %0d both %b exp %0d", k, o.grant, o.both, g); end
            checks++; if (o.cw !== ham_enc(g == 1 ? 8'hB1 : 8'hA0) || o.src !== g[0]) begin errors++; $display("FAIL rr_cw[%0d] got %h src %b exp %h src %0d", k, o.cw, o.src, ham_enc(g == 1 ? 8'hB1 : 8'hA0), g); end
            if (k > 0) begin
                checks++; if (o.acc_cyc - prev !== 4) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp 4", k, o.acc_cyc - prev); end
            end
            prev = o.acc_cyc;
        end
    endtask

    task automatic test_random;
        txn_obs_t o;
        bit v0, v1;
        logic [7:0] d0, d1;
        int g;
        for (int k = 0; k < 24; k++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            g = arb(1'b1, v0, v1, last_m[0]);
            do_txn(1'b0, v0, d0, v1, d1, 0, o);
            model_accept(1'b0, g);
            checks++;
            if (o.grant !== g || o.lat !== 3 || o.src !== g[0] || o.cw !== ham_enc(g == 1 ? d1 : d0)) begin
                errors++;
                $display("FAIL rand[%0d] got g%0d lat%0d src%b cw %h exp g%0d lat3 cw %h", k, o.grant, o.lat, o.src, o.cw, g, ham_enc(g == 1 ? d1 : d0));
            end
        end
        checks++;
        if (o.c0_after !== 16'(cnt_m[0][0]) || o.c1_after !== 16'(cnt_m[0][1])) begin
            errors++; $display("FAIL rand_cnt got %0d/%0d exp %0d/%0d", o.c0_after, o.c1_after, cnt_m[0][0], cnt_m[0][1]);
        end
    endtask

    task automatic test_fixed_priority;
        txn_obs_t o;
        logic [7:0] d0;
        for (int k = 0; k < 6; k++) begin
            d0 = 8'($urandom);
            do_txn(1'b1, 1'b1, d0, 1'b1, 8'($urandom), 0, o);
            model_accept(1'b1, 0);
            checks++;
            if (o.grant !== 0 || o.saw_r1 !== 1'b0 || o.cw !== ham_enc(d0) || o.src !== 1'b0) begin
                errors++; $display("FAIL fp[%0d] got g%0d r1seen %b cw %h exp g0 r1seen 0 cw %h", k, o.grant, o.saw_r1, o.cw, ham_enc(d0));
            end
        end
        do_txn(1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 0, o);
        model_accept(1'b1, 1);
        checks++; if (o.grant !== 1 || o.cw !== ham_enc(8'h5A)) begin errors++; $display("FAIL fp_solo1 got g%0d cw %h exp g1 cw %h", o.grant, o.cw, ham_enc(8'h5A)); end
    endtask

    task automatic test_stall_wrap;
        txn_obs_t o;
        logic [7:0] d0;
        for (int k = 0; k < 4 && cnt_m[1][0] != 3; k++) begin
            do_txn(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 0, o);
            model_accept(1'b1, 0);
        end
        checks++; if (o.c0_after !== 16'd3) begin errors++; $display("FAIL preload_cnt0 got %0d exp 3", o.c0_after); end
        d0 = 8'($urandom);
        do_txn(1'b1, 1'b1, d0, 1'b1, 8'($urandom), 10, o);
        model_accept(1'b1, 0);
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL stall_stable got %b exp 1", o.stable); end
        checks++; if (o.cw !== ham_enc(d0) || o.src !== 1'b0) begin errors++; $display("FAIL stall_cw got %h exp %h", o.cw, ham_enc(d0)); end
        checks++; if (o.c0_after !== 16'd0 || o.c1_after !== 16'(cnt_m[1][1])) begin errors++; $display("FAIL wrap_cnt got %0d/%0d exp 0/%0d", o.c0_after, o.c1_after, cnt_m[1][1]); end
        d0 = 8'($urandom);
        do_txn(1'b0, 1'b0, 8'h00, 1'b1, d0, 10, o);
        model_accept(1'b0, 1);
        checks++; if (o.stable !== 1'b1 || o.cw !== ham_enc(d0)) begin errors++; $display("FAIL stall_a got stable %b cw %h exp 1 %h", o.stable, o.cw, ham_enc(d0)); end
        checks++; if (o.c1_after !== 16'(cnt_m[0][1]) || o.c0_after !== 16'(cnt_m[0][0])) begin errors++; $display("FAIL stall_a_cnt got %0d/%0d exp %0d/%0d", o.c0_after, o.c1_after, cnt_m[0][0], cnt_m[0][1]); end
    endtask

    task automatic test_reset_mid_out;
        txn_obs_t o;
        logic [7:0] d0;
        int n = 0;
        ia.cw_ready = 1'b0;
        drive(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        while (!ia.cw_valid && n < 10) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
            n++;
        end
        checks++; if (ia.cw_valid !== 1'b1) begin errors++; $display("FAIL mid_out_reach got %b exp 1", ia.cw_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ia.cw_valid !== 1'b0 || ia.cw_data !== 12'h0 || ia.cw_src !== 1'b0) begin errors++; $display("FAIL arst_cw got v%b d%h s%b exp 0", ia.cw_valid, ia.cw_data, ia.cw_src); end
        checks++; if (ia.enc_wren !== 1'b0 || ia.busy !== 1'b0 || ia.cnt0 !== 16'h0 || ia.cnt1 !== 16'h0) begin errors++; $display("FAIL arst_state got w%b b%b c%0d/%0d exp 0", ia.enc_wren, ia.busy, ia.cnt0, ia.cnt1); end
        last_m = '{1'b1, 1'b1};
        cnt_m = '{'{0, 0}, '{0, 0}};
        ia.cw_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = 8'($urandom);
        do_txn(1'b0, 1'b1, d0, 1'b1, 8'($urandom), 0, o);
        model_accept(1'b0, 0);
        checks++; if (o.grant !== 0 || o.cw !== ham_enc(d0) || o.c0_after !== 16'd1) begin errors++; $display("FAIL post_rst_tie got g%0d cw %h c0 %0d exp g0 cw %h c0 1", o.grant, o.cw, o.c0_after, ham_enc(d0)); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        ia.cw_ready = 1'b1;
        ib.cw_ready = 1'b1;
        last_m = '{1'b1, 1'b1};
        cnt_m = '{'{0, 0}, '{0, 0}};
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_known_vectors;
        test_round_robin;
        test_random;
        test_fixed_priority;
        test_stall_wrap;
        test_reset_mid_out;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
